duplicated_adder_checker: RTL

Registered checker that sits directly downstream of the 78-bit duplicated carry-select adder and validates its redundant outputs. Each accepted sample is checked two ways:
- **Dual-rail check:** the sum word is compared against its complementary copy.
- **Parity check:** the operand-parity term is compared against the predicted parity of `a^b`.

The block forwards the sum with a two-cycle latency, flags errors per sample, and keeps a sticky error state and a saturating error counter for the fault-management logic.

---
 rtl/duplicated_adder_checker_if.sv | 30 +++
 rtl/duplicated_adder_checker.sv | 96 +++++++++
 2 files changed

// File: rtl/duplicated_adder_checker_if.sv
// Sample and result bundle between the duplicated carry-select adder, the
// checker, and the fault-management logic.
interface duplicated_adder_checker_if #(
  parameter int W     = 78,
  parameter int CNT_W = 16
);
  logic             valid_in;
  logic [W-1:0]     s;
  logic [W-1:0]     s_invert;
  logic             papb;
  logic             pab;
  logic             clear;
  logic             valid_out;
  logic [W-1:0]     sum_out;
  logic             err_dual;
  logic             err_parity;
  logic             err_any;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;

  modport master (
    output valid_in, s, s_invert, papb, pab, clear,
    input  valid_out, sum_out, err_dual, err_parity, err_any, err_sticky, err_count
  );

  modport slave (
    input  valid_in, s, s_invert, papb, pab, clear,
    output valid_out, sum_out, err_dual, err_parity, err_any, err_sticky, err_count
  );
endinterface

// File: rtl/duplicated_adder_checker.sv
// Two-stage dual-rail / parity checker for the duplicated adder, with sticky
// fault FSM and saturating error counter. Parity path enabled by CHECKER_PARITY_EN.
module duplicated_adder_checker #(
  parameter int W     = 78,
  parameter int CNT_W = 16
) (
  input logic                          clk,
  input logic                          rst,
  duplicated_adder_checker_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, OK, FAULT} state_t;

  logic             vld_p1, vld_p2;
  logic [W-1:0]     s_p1, mis_p1, sum_p2;
  logic             dual_p2;
  logic             par_p2;
  logic             err_any;
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;

  // stage 1: capture sample / stage 2: reduce to per-sample flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      s_p1    <= '0;
      mis_p1  <= '0;
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      dual_p2 <= 1'b0;
    end else begin
      vld_p1 <= bus.valid_in;
      if (bus.valid_in) begin
        s_p1   <= bus.s;
        mis_p1 <= bus.s ^ bus.s_invert;
      end
      vld_p2  <= vld_p1;
      sum_p2  <= s_p1;
      dual_p2 <= vld_p1 & ~(&mis_p1);
    end
  end

`ifdef CHECKER_PARITY_EN
  logic par_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_p1 <= 1'b0;
      par_p2 <= 1'b0;
    end else begin
      if (bus.valid_in) par_p1 <= bus.papb ^ bus.pab;
      par_p2 <= vld_p1 & par_p1;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = bus.papb ^ bus.pab;
  assign par_p2        = 1'b0;
`endif

  assign err_any = dual_p2 | par_p2;

  // fault tracking: acts on flags presented this cycle, clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (bus.clear)
      state_nxt = IDLE;
    else if (vld_p2 && err_any)
      state_nxt = FAULT;
    else if (vld_p2 && state_q == IDLE)
      state_nxt = OK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (bus.clear)
      cnt_q <= '0;
    else if (vld_p2 && err_any && cnt_q != {CNT_W{1'b1}})
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.valid_out  = vld_p2;
  assign bus.sum_out    = sum_p2;
  assign bus.err_dual   = dual_p2;
  assign bus.err_parity = par_p2;
  assign bus.err_any    = err_any;
  assign bus.err_sticky = (state_q == FAULT);
  assign bus.err_count  = cnt_q;

endmodule
